pwm_multi_channel: RTL and testbench

Parametrised successor to the single-duty 16-output PWM peripheral. Provides NUM_CH channels, each with its own duty register, plus a shared prescaler, programmable period and edge- or center-aligned counting. Duty, period and mode changes are double-buffered so they take effect only at a period boundary. Sits behind the register interface and drives the chip's dedicated and bidirectional outputs as one flat vector.

---
 rtl/pwm_multi_channel.sv | 108 ++++++++++
 tb/tb_pwm_multi_channel.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_channel
// Brief    : NUM_CH-channel PWM with shared prescaler, edge/center counting and
//            period-boundary double-buffering of duty, period and mode.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_channel #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int PRE_W  = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en_out,
    input  logic [NUM_CH-1:0] en_pwm,
    input  logic [PRE_W-1:0]  prescale,
    input  logic [CNT_W-1:0]  period,
    input  logic              center,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_duty,
    output logic [NUM_CH-1:0] out,
    output logic              period_tick
);

    logic [PRE_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_dir_down;
    logic              w_dir_down_nxt;
    logic [CNT_W-1:0]  r_active_period;
    logic              r_active_center;
    logic [CNT_W-1:0]  r_pending     [NUM_CH];
    logic [CNT_W-1:0]  r_active_duty [NUM_CH];
    logic              w_tick;
    logic              w_boundary;
    logic              r_start;
    logic [NUM_CH-1:0] w_out_nxt;

    assign w_tick = (r_pre_cnt >= prescale);

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_dir_down_nxt = r_dir_down;
        if (!r_active_center) begin
            w_cnt_nxt = (r_cnt >= r_active_period) ? '0 : r_cnt + CNT_W'(1);
        end else if (r_dir_down) begin
            w_cnt_nxt = (r_cnt <= CNT_W'(1)) ? '0 : r_cnt - CNT_W'(1);
        end else if (r_cnt >= r_active_period) begin
            // Turn around at the top; P=0 collapses to a single-tick period.
            w_cnt_nxt      = (r_active_period == '0) ? '0 : r_active_period - CNT_W'(1);
            w_dir_down_nxt = 1'b1;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign w_boundary = w_tick && (w_cnt_nxt == '0);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_out_nxt[gi] = en_out[gi] & (~en_pwm[gi] | (r_cnt < r_active_duty[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre_cnt       <= '0;
            r_cnt           <= '0;
            r_dir_down      <= 1'b0;
            r_active_period <= '0;
            r_active_center <= 1'b0;
            r_start         <= 1'b0;
            period_tick     <= 1'b0;
            out             <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pending[i]     <= '0;
                r_active_duty[i] <= '0;
            end
        end else begin
            if (w_tick) begin
                r_pre_cnt  <= '0;
                r_cnt      <= w_cnt_nxt;
                r_dir_down <= w_boundary ? 1'b0 : w_dir_down_nxt;
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
            // Boundary copies the pre-write pending value; a same-clock write lands next period.
            if (w_boundary) begin
                r_active_period <= period;
                r_active_center <= center;
                for (int i = 0; i < NUM_CH; i++) begin
                    r_active_duty[i] <= r_pending[i];
                end
            end
            if (wr_en && (32'(wr_ch) < NUM_CH)) begin
                r_pending[wr_ch] <= wr_duty;
            end
            r_start     <= w_boundary;
            period_tick <= r_start;
            out         <= w_out_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// Directed plus randomized bench; a period-position model predicts out/period_tick every clock.
module tb_pwm_multi_channel;

    localparam int NUM_CH = 16;
    localparam int CNT_W  = 8;
    localparam int PRE_W  = 4;
    localparam int CH_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [PRE_W-1:0]  prescale;
    logic [CNT_W-1:0]  period;
    logic              center;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_duty;
    logic [NUM_CH-1:0] out;
    logic              period_tick;

    pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst_n(rst_n), .en_out(en_out), .en_pwm(en_pwm),
        .prescale(prescale), .period(period), .center(center),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .out(out), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the period, in prescaled ticks.
    int          m_pre, m_pos, m_P;
    bit          m_center;
    int          m_act  [NUM_CH];
    int          m_pend [NUM_CH];
    logic [15:0] m_out;
    logic        m_ptick, m_start;

    bit bw_armed = 1'b0;
    int bw_val   = 0;

    int hi [NUM_CH];
    int ticks, upper, low3;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int plen();
        if (m_center) return (m_P == 0) ? 1 : 2 * m_P;
        return m_P + 1;
    endfunction

    function automatic int cnt_of(int pos);
        if (m_center && pos > m_P) return 2 * m_P - pos;
        return pos;
    endfunction

    function automatic bit bnd_next();
        return rst_n && (m_pre >= int'(prescale)) && (m_pos + 1 >= plen());
    endfunction

    task automatic model_update();
        logic [15:0] o_n;
        int c;
        if (!rst_n) begin
            m_pre = 0; m_pos = 0; m_P = 0; m_center = 0;
            m_out = '0; m_ptick = 0; m_start = 0;
            for (int i = 0; i < NUM_CH; i++) begin m_act[i] = 0; m_pend[i] = 0; end
        end else begin
            c = cnt_of(m_pos);
            for (int i = 0; i < NUM_CH; i++)
                o_n[i] = en_out[i] && (!en_pwm[i] || (c < m_act[i]));
            m_ptick = m_start;
            m_out   = o_n;
            m_start = 0;
            if (m_pre >= int'(prescale)) begin
                m_pre = 0;
                m_pos++;
                if (m_pos >= plen()) begin
                    m_pos = 0; m_start = 1;
                    m_P = int'(period); m_center = center;
                    for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
                end
            end else begin
                m_pre++;
            end
            if (wr_en && int'(wr_ch) < NUM_CH) m_pend[wr_ch] = int'(wr_duty);
        end
    endtask

    task automatic step();
        if (bw_armed && bnd_next()) begin
            wr_en = 1'b1; wr_ch = '0; wr_duty = CNT_W'(bw_val); bw_armed = 1'b0;
        end
        model_update();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("out", 64'(out), 64'(m_out));
        check("period_tick", 64'(period_tick), 64'(m_ptick));
    endtask

    task automatic wait_tick(int bound);
        int n = 0;
        while (period_tick !== 1'b1 && n < bound) begin step(); n++; end
        check("wait_tick", 64'(period_tick), 64'd1);
    endtask

    task automatic measure(int n);
        ticks = 0; upper = 0; low3 = 0;
        for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            for (int i = 0; i < NUM_CH; i++) if (out[i]) hi[i]++;
            if (period_tick) ticks++;
            if (out[15:3] != '0) upper++;
            if (out[2:0] != '0) low3++;
        end
    endtask

    task automatic write(int ch, int duty);
        wr_en = 1'b1; wr_ch = CH_W'(ch); wr_duty = CNT_W'(duty);
        step();
    endtask

    initial begin
        rst_n = 0; en_out = '0; en_pwm = '0; prescale = '0; period = '0;
        center = 0; wr_en = 0; wr_ch = '0; wr_duty = '0;
        step(); step();
        check("rst_out", 64'(out), 64'd0);
        check("rst_tick", 64'(period_tick), 64'd0);
        rst_n = 1;

        // Edge mode, P=255, three channels
        en_out = 16'h0007; en_pwm = 16'h0007;
        write(0, 64); write(1, 0); write(2, 255);
        period = 8'd255;
        step(); step();
        wait_tick(10);
        measure(256);
        check("t1_ch0_hi", 64'(hi[0]), 64'd64);
        check("t1_ch1_hi", 64'(hi[1]), 64'd0);
        check("t1_ch2_hi", 64'(hi[2]), 64'd255);
        check("t1_upper", 64'(upper), 64'd0);
        check("t1_ticks", 64'(ticks), 64'd1);
        step();
        check("t1_spacing", 64'(period_tick), 64'd1);

        // Static-high channel
        en_out = 16'h000F; en_pwm = 16'h0007;
        step();
        check("t2_out3", 64'(out[3]), 64'd1);
        step(); step();
        check("t2_out3_hold", 64'(out[3]), 64'd1);

        // Prescaled edge mode
        prescale = 4'd3; period = 8'd9;
        write(0, 5);
        step(); step();
        wait_tick(3000);
        measure(40);
        check("t3_ch0_hi", 64'(hi[0]), 64'd20);
        check("t3_ticks", 64'(ticks), 64'd1);
        step();
        check("t3_spacing", 64'(period_tick), 64'd1);

        // Center mode
        prescale = 4'd0; center = 1'b1; period = 8'd10;
        write(0, 4);
        step(); step();
        wait_tick(200);
        measure(20);
        check("t4_ch0_hi", 64'(hi[0]), 64'd7);
        check("t4_ticks", 64'(ticks), 64'd1);
        step();
        check("t4_spacing", 64'(period_tick), 64'd1);

        // Mid-period write, then a write on the exact boundary clock
        wr_en = 1'b1; wr_ch = '0; wr_duty = 8'd200;
        measure(20);
        check("t5_p1_hi", 64'(hi[0]), 64'd7);
        step();
        check("t5_p2_tick", 64'(period_tick), 64'd1);
        bw_armed = 1'b1; bw_val = 2;
        measure(20);
        check("t5_p2_hi", 64'(hi[0]), 64'd20);
        check("t5_bw_fired", 64'(bw_armed), 64'd0);
        step();
        measure(20);
        check("t5_p3_hi", 64'(hi[0]), 64'd20);
        step();
        check("t5_p4_tick", 64'(period_tick), 64'd1);
        measure(20);
        check("t5_p4_hi", 64'(hi[0]), 64'd3);

        // Reset mid-period while out[3] is high
        step(); step(); step();
        rst_n = 0;
        step();
        check("t6_rst_out", 64'(out), 64'd0);
        check("t6_rst_tick", 64'(period_tick), 64'd0);
        rst_n = 1;
        step();
        measure(40);
        check("t6_pwm_low", 64'(low3), 64'd0);
        check("t6_out3", 64'(out[3]), 64'd1);

        // Randomized segments
        for (int s = 0; s < 8; s++) begin
            prescale = PRE_W'($urandom_range(0, 3));
            period   = CNT_W'($urandom_range(0, 12));
            center   = 1'($urandom_range(0, 1));
            en_out   = NUM_CH'($urandom);
            en_pwm   = NUM_CH'($urandom);
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    wr_en = 1'b1;
                    wr_ch = CH_W'($urandom_range(0, NUM_CH - 1));
                    wr_duty = CNT_W'($urandom_range(0, 14));
                end
                rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
                step();
            end
            rst_n = 1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
